// File: rtl/pixel_stream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pixel_stream_loader
// Purpose  : Accepts a byte stream from the host link (valid/ready), pairs
//            low/high bytes into signed pixels and writes them sequentially
//            into the picture buffer. After the last pixel of a frame it
//            pulses go_o for one cycle, then refuses input until release_i.
// Ports    : clk           - clock, all state changes on rising edge
//            rst_n         - asynchronous active-low reset
//            in_data_i     - stream byte
//            in_valid_i    - stream byte valid
//            in_ready_o    - loader accepts a byte this cycle
//            abort_i       - synchronous frame discard, any state
//            release_i     - downstream finished with buffer
//            buf_we_o      - buffer write strobe, one cycle per pixel
//            buf_addr_o    - buffer write address
//            buf_data_o    - signed pixel value written
//            go_o          - one-cycle frame-ready pulse
//            busy_o        - frame in progress / awaiting release
// Revision : 1.0 - initial release
// ============================================================================
module pixel_stream_loader #(
    parameter int PICTURE_SIZE     = 28,
    parameter int SIZE_1           = 11,
    parameter int SIZE_ADDRESS_PIX = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in_data_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        abort_i,
    input  logic                        release_i,
    output logic                        buf_we_o,
    output logic [SIZE_ADDRESS_PIX-1:0] buf_addr_o,
    output logic [SIZE_1-1:0]           buf_data_o,
    output logic                        go_o,
    output logic                        busy_o
);

    localparam int N = PICTURE_SIZE * PICTURE_SIZE;
    localparam logic [SIZE_ADDRESS_PIX-1:0] LAST_PIX = SIZE_ADDRESS_PIX'(N - 1);

    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        S_HI   = 2'd1,
        S_GO   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                      state_q,    state_d;
    logic [SIZE_ADDRESS_PIX-1:0] pix_cnt_q,  pix_cnt_d;
    logic [7:0]                  lo_q,       lo_d;
    logic                        in_ready_q, in_ready_d;
    logic                        buf_we_q,   buf_we_d;
    logic [SIZE_ADDRESS_PIX-1:0] buf_addr_q, buf_addr_d;
    logic [SIZE_1-1:0]           buf_data_q, buf_data_d;
    logic                        busy_q,     busy_d;

    logic                        xfer;

    // in_ready is registered from the next state so it stays low during
    // reset and rises on the first clock after reset is released.
    assign xfer = in_valid_i & in_ready_q;

    // Bits of the high byte above the pixel width are deliberately discarded.
    generate
        if (SIZE_1 < 16) begin : g_unused_hi
            logic unused_hi_bits;
            assign unused_hi_bits = ^in_data_i[7:SIZE_1-8];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        lo_d       = lo_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        busy_d     = busy_q;

        if (abort_i) begin
            // Discard the frame; any byte presented this cycle is dropped.
            state_d   = S_LO;
            pix_cnt_d = '0;
            lo_d      = 8'd0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_LO: begin
                    if (xfer) begin
                        lo_d    = in_data_i;
                        busy_d  = 1'b1;
                        state_d = S_HI;
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        buf_we_d   = 1'b1;
                        buf_addr_d = pix_cnt_q;
                        buf_data_d = {in_data_i[SIZE_1-9:0], lo_q};
                        if (pix_cnt_q == LAST_PIX) begin
                            pix_cnt_d = '0;
                            state_d   = S_GO;
                        end else begin
                            pix_cnt_d = pix_cnt_q + SIZE_ADDRESS_PIX'(1);
                            state_d   = S_LO;
                        end
                    end
                end
                S_GO: begin
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (release_i) begin
                        busy_d  = 1'b0;
                        state_d = S_LO;
                    end
                end
                default: begin
                    state_d = S_LO;
                end
            endcase
        end

        in_ready_d = (state_d == S_LO) || (state_d == S_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LO;
            pix_cnt_q  <= '0;
            lo_q       <= 8'd0;
            in_ready_q <= 1'b0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            lo_q       <= lo_d;
            in_ready_q <= in_ready_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign buf_we_o   = buf_we_q;
    assign buf_addr_o = buf_addr_q;
    assign buf_data_o = buf_data_q;
    assign busy_o     = busy_q;
    // GO lines up with the final pixel's write strobe; abort suppresses it.
    assign go_o       = (state_q == S_GO) && !abort_i;

endmodule
`default_nettype wire
